i2c_cmd_engine: RTL and testbench

//  Byte-level I2C master that sits directly downstream of the QSFP/sideband command state machines.

---
 rtl/i2c_cmd_engine.sv | 185 ++++++++++++++++++
 tb/tb_i2c_cmd_engine.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_engine.sv
// Byte-level I2C master: one register read/write per IO_CONTROL_PULSE on open-drain SCL/SDA.
// Optional I2C_CLK_STRETCH_EN: honour slave clock stretching during data/ACK bits.
module i2c_cmd_engine #(
  parameter logic [15:0] CLK_DIV = 16'd250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       IO_CONTROL_PULSE,
  input  logic       IO_CONTROL_RW,
  input  logic [7:0] IO_CONTROL_ID,
  input  logic [7:0] IO_ADDR_ADDR,
  input  logic [7:0] IO_WDATA_WDATA,
  output logic [7:0] IO_RDATA_RDATA,
  output logic       IO_CONTROL_CMPLT,
  output logic       IO_CONTROL_NACK,
  output logic       busy,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_t,
  output logic       sda_t
);

  typedef enum logic [2:0] {IDLE, START, TX_BYTE, RESTART, RX_BYTE, STOP, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] qcnt;
  logic [1:0]  quarter;
  logic [2:0]  bit_cnt;
  logic        ack_bit;
  logic [1:0]  byte_idx;
  logic        cmd_rw;
  logic [6:0]  cmd_id;
  logic [7:0]  cmd_addr, cmd_wdata;
  logic [7:0]  tx_sh, rx_sh;
  logic        got_nack;
  logic        accept, bus_state, bit_state, stall, tick, q_end, sample;
  logic        scl_nxt, sda_nxt;
  logic        unused_inputs;

  assign unused_inputs = ^{scl_i, IO_CONTROL_ID[0]};

  assign busy      = (state != IDLE) || IO_CONTROL_CMPLT;
  assign accept    = IO_CONTROL_PULSE && !busy;
  assign bit_state = (state == TX_BYTE) || (state == RX_BYTE);
  assign bus_state = bit_state || (state == START) || (state == RESTART) || (state == STOP);

`ifdef I2C_CLK_STRETCH_EN
  assign stall = bit_state && (quarter == 2'd2) && !scl_i;
`else
  assign stall = 1'b0;
`endif

  assign tick   = bus_state && (qcnt == '0) && !stall;
  assign q_end  = tick && (quarter == 2'd3);
  assign sample = tick && (quarter == 2'd2);

  always_comb begin
    state_nxt = state;
    scl_nxt   = 1'b1;
    sda_nxt   = 1'b1;
    case (state)
      IDLE: if (accept) state_nxt = START;
      START: begin
        scl_nxt = (quarter != 2'd3);
        sda_nxt = !quarter[1];
        if (q_end) state_nxt = TX_BYTE;
      end
      TX_BYTE: begin
        scl_nxt = ^quarter;
        sda_nxt = ack_bit | tx_sh[7];
        if (q_end && ack_bit) begin
          if (got_nack) state_nxt = STOP;
          else begin
            case (byte_idx)
              2'd0: state_nxt = TX_BYTE;
              2'd1: state_nxt = cmd_rw ? RESTART : TX_BYTE;
              2'd2: state_nxt = STOP;
              default: state_nxt = RX_BYTE;
            endcase
          end
        end
      end
      // SCL held low in Q0 so releasing SDA after the ACK slot is not seen as STOP
      RESTART: begin
        scl_nxt = ^quarter;
        sda_nxt = !quarter[1];
        if (q_end) state_nxt = TX_BYTE;
      end
      RX_BYTE: begin
        scl_nxt = ^quarter;
        if (q_end && ack_bit) state_nxt = STOP;
      end
      STOP: begin
        scl_nxt = (quarter != 2'd0);
        sda_nxt = quarter[1];
        if (q_end) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      qcnt             <= '0;
      quarter          <= '0;
      bit_cnt          <= '0;
      ack_bit          <= 1'b0;
      byte_idx         <= '0;
      cmd_rw           <= 1'b0;
      cmd_id           <= '0;
      cmd_addr         <= '0;
      cmd_wdata        <= '0;
      tx_sh            <= '0;
      rx_sh            <= '0;
      got_nack         <= 1'b0;
      IO_RDATA_RDATA   <= '0;
      IO_CONTROL_CMPLT <= 1'b0;
      IO_CONTROL_NACK  <= 1'b0;
      scl_t            <= 1'b1;
      sda_t            <= 1'b1;
    end else begin
      state            <= state_nxt;
      scl_t            <= scl_nxt;
      sda_t            <= sda_nxt;
      IO_CONTROL_CMPLT <= 1'b0;
      if (accept) begin
        cmd_rw    <= IO_CONTROL_RW;
        cmd_id    <= IO_CONTROL_ID[7:1];
        cmd_addr  <= IO_ADDR_ADDR;
        cmd_wdata <= IO_WDATA_WDATA;
        tx_sh     <= {IO_CONTROL_ID[7:1], 1'b0};
        qcnt      <= CLK_DIV - 16'd1;
        quarter   <= '0;
        bit_cnt   <= '0;
        ack_bit   <= 1'b0;
        byte_idx  <= '0;
        got_nack  <= 1'b0;
      end else begin
        if (tick) begin
          qcnt    <= CLK_DIV - 16'd1;
          quarter <= quarter + 2'd1;
        end else if (bus_state && !stall) begin
          qcnt <= qcnt - 16'd1;
        end
        if (sample && bit_state) begin
          if (ack_bit) begin
            if (state == TX_BYTE && sda_i) got_nack <= 1'b1;
          end else if (state == RX_BYTE) begin
            rx_sh <= {rx_sh[6:0], sda_i};
          end
        end
        if (q_end && bit_state) begin
          if (!ack_bit) begin
            tx_sh   <= {tx_sh[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) ack_bit <= 1'b1;
          end else begin
            ack_bit <= 1'b0;
            if (state == TX_BYTE) begin
              case (byte_idx)
                2'd0: begin
                  tx_sh    <= cmd_addr;
                  byte_idx <= 2'd1;
                end
                2'd1: begin
                  tx_sh    <= cmd_rw ? {cmd_id, 1'b1} : cmd_wdata;
                  byte_idx <= cmd_rw ? 2'd3 : 2'd2;
                end
                default: ;
              endcase
            end
          end
        end
        if (state == DONE) begin
          IO_CONTROL_CMPLT <= 1'b1;
          IO_CONTROL_NACK  <= got_nack;
          if (cmd_rw && !got_nack) IO_RDATA_RDATA <= rx_sh;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_cmd_engine.sv
// Bench for i2c_cmd_engine: behavioural I2C slave on the bus, table vectors, corner sequences
// and randomized commands checked against a byte-sequence reference model.
module tb_i2c_cmd_engine;
  localparam logic [15:0] DIV = 16'd4;
  localparam int D = 4;
  localparam int LIMIT = 60 * 4 * D + 200;
  localparam int EV_S = 256, EV_SR = 257, EV_P = 258;

  logic clk = 1'b0;
  logic rst, pulse, rw;
  logic [7:0] id, addr, wdata, rdata;
  logic cmplt, nack, busy, scl_i, sda_i, scl_t, sda_t;
  logic slave_scl = 1'b1, slave_sda = 1'b1;

  assign scl_i = scl_t & slave_scl;
  assign sda_i = sda_t & slave_sda;

  always #5 clk = ~clk;

  i2c_cmd_engine #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst),
    .IO_CONTROL_PULSE(pulse), .IO_CONTROL_RW(rw), .IO_CONTROL_ID(id),
    .IO_ADDR_ADDR(addr), .IO_WDATA_WDATA(wdata), .IO_RDATA_RDATA(rdata),
    .IO_CONTROL_CMPLT(cmplt), .IO_CONTROL_NACK(nack), .busy(busy),
    .scl_i(scl_i), .sda_i(sda_i), .scl_t(scl_t), .sda_t(sda_t)
  );

  int n_vec = 0, n_err = 0;
  int cmplt_cnt = 0;
  always @(posedge clk) if (cmplt) cmplt_cnt <= cmplt_cnt + 1;

  // slave configuration and observed bus events
  logic [6:0] sl_addr;
  bit         sl_present, stretch_en;
  logic [7:0] sl_rdval;
  int         bus_log[$];

  // reference model expectations
  int         exp_log[$];
  bit         exp_nack;
  logic [7:0] exp_rdata, model_rdata;
  int         exp_slots;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Expected bus transcript from the protocol rules: slave ACKs only its own address.
  task automatic model(input bit r, input logic [7:0] i, input logic [7:0] a, input logic [7:0] w);
    bit hit;
    hit = sl_present && (i[7:1] == sl_addr);
    exp_log = {};
    exp_log.push_back(EV_S);
    exp_log.push_back(int'({i[7:1], 1'b0}));
    if (!hit) begin
      exp_log.push_back(EV_P);
      exp_nack  = 1'b1;
      exp_slots = 1 + 9 + 1;
    end else if (r) begin
      exp_log.push_back(int'(a));
      exp_log.push_back(EV_SR);
      exp_log.push_back(int'({i[7:1], 1'b1}));
      exp_log.push_back(int'(sl_rdval));
      exp_log.push_back(EV_P);
      exp_nack    = 1'b0;
      model_rdata = sl_rdval;
      exp_slots   = 1 + 18 + 1 + 18 + 1;
    end else begin
      exp_log.push_back(int'(a));
      exp_log.push_back(int'(w));
      exp_log.push_back(EV_P);
      exp_nack  = 1'b0;
      exp_slots = 1 + 27 + 1;
    end
    exp_rdata = model_rdata;
  endtask

  task automatic run_cmd(input bit r, input logic [7:0] i, input logic [7:0] a,
                         input logic [7:0] w, input int dup_at, output int lat);
    bus_log = {};
    @(posedge clk); #1;
    pulse = 1'b1; rw = r; id = i; addr = a; wdata = w;
    @(posedge clk); #1;
    pulse = 1'b0;
    lat = 1;
    check("busy_after_accept", busy, 1);
    while (!cmplt && lat < LIMIT) begin
      if (lat == dup_at) begin
        pulse = 1'b1; rw = ~r; id = ~i; addr = ~a; wdata = ~w;
      end else pulse = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    pulse = 1'b0;
    check("cmplt_seen", cmplt, 1);
  endtask

  task automatic check_done(input int lat);
    check_range("latency", lat, exp_slots * 4 * D + 2, exp_slots * 4 * D + 4);
    check("nack", nack, exp_nack);
    check("rdata", rdata, exp_rdata);
    check("busy_at_cmplt", busy, 1);
    @(posedge clk); #1;
    check("cmplt_width", cmplt, 0);
    check("busy_after", busy, 0);
    check("bus_len", bus_log.size(), exp_log.size());
    if (bus_log.size() == exp_log.size())
      foreach (exp_log[k]) check("bus_item", bus_log[k], exp_log[k]);
  endtask

  // Behavioural slave: decodes START/STOP/bytes from line levels, ACKs, returns read data,
  // optionally stretches SCL on bit 3 of the first byte.
  initial begin : slave
    bit scl, sda, pscl, psda, pscl_t, in_xfer, addr_phase, tx_mode, pend_tx, hit;
    int bitcnt, fcnt, hold;
    logic [7:0] sh, txb;
    pscl = 1; psda = 1; pscl_t = 1; in_xfer = 0; addr_phase = 0; tx_mode = 0;
    pend_tx = 0; hit = 0; bitcnt = 0; fcnt = 0; hold = 0; sh = '0; txb = '0;
    forever begin
      @(negedge clk);
      scl = scl_i;
      sda = sda_i;
      if (rst) begin
        in_xfer = 0; tx_mode = 0; pend_tx = 0; hit = 0; bitcnt = 0; fcnt = 0; hold = 0;
        slave_sda = 1'b1; slave_scl = 1'b1;
      end else begin
        if (pscl && scl && psda && !sda) begin
          bus_log.push_back(in_xfer ? EV_SR : EV_S);
          in_xfer = 1; bitcnt = 0; addr_phase = 1; tx_mode = 0; pend_tx = 0; hit = 0;
          fcnt = 0; slave_sda = 1'b1;
        end else if (pscl && scl && !psda && sda) begin
          bus_log.push_back(EV_P);
          in_xfer = 0; tx_mode = 0; slave_sda = 1'b1;
        end else if (in_xfer && !pscl && scl) begin
          if (bitcnt < 8) begin
            sh = {sh[6:0], sda};
            bitcnt++;
          end
        end else if (in_xfer && pscl && !scl) begin
          if (bitcnt == 8) begin
            bus_log.push_back(int'(sh));
            if (tx_mode) slave_sda = 1'b1;
            else begin
              if (addr_phase) begin
                hit     = sl_present && (sh[7:1] == sl_addr);
                pend_tx = hit && sh[0];
              end
              slave_sda = !hit;
            end
            bitcnt = 9;
          end else if (bitcnt == 9) begin
            slave_sda = 1'b1; bitcnt = 0; addr_phase = 0;
            if (tx_mode) tx_mode = 0;
            else if (pend_tx) begin
              tx_mode = 1; pend_tx = 0; txb = sl_rdval; slave_sda = txb[7];
            end
          end else if (tx_mode) begin
            slave_sda = txb[7 - bitcnt];
          end
        end
        if (pscl_t && !scl_t) begin
          fcnt++;
          // held from the fall before bit 3 until 50 clk past the master's nominal Q2 start
          if (stretch_en && fcnt == 4) hold = 3 * D + 50;
        end
        if (hold > 0) begin
          slave_scl = 1'b0;
          hold--;
        end else slave_scl = 1'b1;
      end
      pscl = scl; psda = sda; pscl_t = scl_t;
    end
  end

  typedef struct {
    bit         rw;
    logic [7:0] id, addr, wdata;
    logic [6:0] sl_addr;
    bit         present;
    logic [7:0] rdval;
    bit         exp_nack;
    logic [7:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int lat, lat0, c0;

    tbl[0] = '{0, 8'hE0, 8'h01, 8'h01, 7'h70, 1, 8'h00, 0, 8'h00};
    tbl[1] = '{1, 8'h40, 8'h00, 8'h00, 7'h20, 1, 8'hA5, 0, 8'hA5};
    tbl[2] = '{0, 8'hA0, 8'h12, 8'h34, 7'h50, 0, 8'h00, 1, 8'hA5};
    tbl[3] = '{0, 8'hE1, 8'h7F, 8'h80, 7'h70, 1, 8'h00, 0, 8'hA5};
    tbl[4] = '{1, 8'h41, 8'hFF, 8'h00, 7'h21, 1, 8'h99, 1, 8'hA5};
    tbl[5] = '{1, 8'h43, 8'h10, 8'h00, 7'h21, 1, 8'h3C, 0, 8'h3C};

    rst = 1'b1; pulse = 1'b0; rw = 1'b0; id = '0; addr = '0; wdata = '0;
    sl_addr = '0; sl_present = 0; stretch_en = 0; sl_rdval = '0; model_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 0);
    check("rst_cmplt", cmplt, 0);
    check("rst_nack", nack, 0);
    check("rst_busy", busy, 0);
    check("rst_scl_t", scl_t, 1);
    check("rst_sda_t", sda_t, 1);
    rst = 1'b0;

    foreach (tbl[v]) begin
      sl_addr = tbl[v].sl_addr; sl_present = tbl[v].present; sl_rdval = tbl[v].rdval;
      model(tbl[v].rw, tbl[v].id, tbl[v].addr, tbl[v].wdata);
      exp_nack  = tbl[v].exp_nack;
      exp_rdata = tbl[v].exp_rdata;
      run_cmd(tbl[v].rw, tbl[v].id, tbl[v].addr, tbl[v].wdata, 0, lat);
      check_done(lat);
    end

    // second pulse while busy must be dropped
    sl_addr = 7'h50; sl_present = 1;
    c0 = cmplt_cnt;
    model(0, 8'hA0, 8'h11, 8'h22);
    run_cmd(0, 8'hA0, 8'h11, 8'h22, 10, lat);
    check_done(lat);
    repeat (40 * 4 * D) @(posedge clk);
    #1;
    check("dup_cmplt_count", cmplt_cnt - c0, 1);
    check("dup_idle", busy, 0);
    check("dup_bus_len", bus_log.size(), exp_log.size());

    // reset in the middle of bit 5 of the ADDR byte
    sl_addr = 7'h70; sl_present = 1;
    bus_log = {};
    @(posedge clk); #1;
    pulse = 1'b1; rw = 1'b0; id = 8'hE0; addr = 8'h5A; wdata = 8'h3C;
    @(posedge clk); #1;
    pulse = 1'b0;
    repeat (62 * D - 1) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    c0 = cmplt_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_scl_t", scl_t, 1);
    check("mid_rst_sda_t", sda_t, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmplt", cmplt, 0);
    repeat (200) @(posedge clk);
    #1;
    check("mid_rst_no_cmplt", cmplt_cnt - c0, 0);
    model_rdata = '0;
    model(0, 8'hE0, 8'h5A, 8'h3C);
    run_cmd(0, 8'hE0, 8'h5A, 8'h3C, 0, lat);
    check_done(lat);

    // clock stretching on bit 3 of the address byte (no slave: NACK path)
    sl_present = 0;
    stretch_en = 0;
    model(0, 8'h90, 8'h00, 8'h00);
    run_cmd(0, 8'h90, 8'h00, 8'h00, 0, lat0);
    check_done(lat0);
    stretch_en = 1;
    run_cmd(0, 8'h90, 8'h00, 8'h00, 0, lat);
    check("stretch_nack", nack, 1);
`ifdef I2C_CLK_STRETCH_EN
    check_range("stretch_extra", lat - lat0, 48, 52);
`else
    check("stretch_ignored", lat - lat0, 0);
`endif
    stretch_en = 0;
    repeat (4 * D) @(posedge clk);

    for (int n = 0; n < 16; n++) begin
      logic [7:0] ri, ra, rwd;
      bit rr;
      rr  = $urandom_range(0, 1) == 1;
      ri  = 8'($urandom);
      ra  = 8'($urandom);
      rwd = 8'($urandom);
      sl_present = $urandom_range(0, 3) != 0;
      sl_addr    = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ri[7:1];
      sl_rdval   = 8'($urandom);
      model(rr, ri, ra, rwd);
      run_cmd(rr, ri, ra, rwd, 0, lat);
      check_done(lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
